// File: rtl/tick_rate_scheduler.sv
// Free-running timebase with a divider-selected bit, rising-edge tick and a
// start/stop divider sweep engine with start/busy/done handshaking.
module tick_rate_scheduler #(
  parameter int CNT_W   = 32,
  parameter int OFFSET  = 25,
  parameter int DWELL_W = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [7:0]         cfg_div,
  input  logic [7:0]         cfg_div_stop,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_wrap,
  input  logic               start,
  input  logic               abort,
  output logic               bit_out,
  output logic               tick,
  output logic [7:0]         cur_div,
  output logic               busy,
  output logic               done
);

  localparam int               IDX_W      = $clog2(CNT_W);
  localparam logic [7:0]       OFFSET_DIV = 8'(OFFSET);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bit_q, bit_d;
  logic               tick_q, tick_d;
  logic               div_chg_q, div_chg_d;
  logic [7:0]         cur_div_q, cur_div_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IDX_W-1:0]   idx_s;
  logic               prev_s;
  logic [DWELL_W-1:0] dwell_nxt_s;

  // A zero dwell would never let a step finish, so it behaves as one tick.
  function automatic logic [DWELL_W-1:0] dwell_limit(input logic [DWELL_W-1:0] d);
    logic [DWELL_W-1:0] lim;
    if (d == {DWELL_W{1'b0}}) begin
      lim = {{(DWELL_W-1){1'b0}}, 1'b1};
    end else begin
      lim = d;
    end
    return lim;
  endfunction

  // Unsigned compare first so dividers above OFFSET clamp to bit 0.
  always_comb begin
    if (cur_div_q <= OFFSET_DIV) begin
      idx_s = IDX_W'(OFFSET_DIV - cur_div_q);
    end else begin
      idx_s = {IDX_W{1'b0}};
    end
  end

  // Right after a divider change the history is reloaded with the new bit so
  // the index jump itself can never look like a rising edge.
  always_comb begin
    cnt_d     = cnt_q + CNT_ONE;
    bit_d     = cnt_q[idx_s];
    prev_s    = div_chg_q ? bit_d : bit_q;
    tick_d    = bit_d & ~prev_s;
    div_chg_d = (cur_div_d != cur_div_q);
  end

  always_comb begin
    state_d     = state_q;
    cur_div_d   = cur_div_q;
    dwell_d     = dwell_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dwell_nxt_s = dwell_q + {{(DWELL_W-1){1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        cur_div_d = cfg_div;
        busy_d    = 1'b0;
        if (start && !abort) begin
          dwell_d = {DWELL_W{1'b0}};
          busy_d  = 1'b1;
          state_d = SWEEP;
        end else begin
          dwell_d = dwell_q;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          dwell_d = {DWELL_W{1'b0}};
        end else if (tick_q) begin
          // The tick that completes a dwell still belongs to the old divider.
          if (dwell_nxt_s >= dwell_limit(cfg_dwell)) begin
            dwell_d = {DWELL_W{1'b0}};
            if (cur_div_q != cfg_div_stop) begin
              if (cfg_div_stop > cfg_div) begin
                cur_div_d = cur_div_q + 8'd1;
              end else begin
                cur_div_d = cur_div_q - 8'd1;
              end
            end else if (cfg_wrap) begin
              cur_div_d = cfg_div;
            end else begin
              state_d = FINISH;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            dwell_d = dwell_nxt_s;
          end
        end else begin
          dwell_d = dwell_q;
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state, synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      bit_q     <= 1'b0;
      tick_q    <= 1'b0;
      div_chg_q <= 1'b0;
      cur_div_q <= 8'd0;
      dwell_q   <= {DWELL_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tick_q    <= tick_d;
      div_chg_q <= div_chg_d;
      cur_div_q <= cur_div_d;
      dwell_q   <= dwell_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bit_out = bit_q;
  assign tick    = tick_q;
  assign cur_div = cur_div_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
